multi_alarm_clock: RTL and testbench
====================================

Name: multi_alarm_clock

Overview:
- Parametrised 24-hour clock for the six-digit 7-segment board display: timekeeping, time set, NUM_ALARMS independent alarms and a 1/100 s stopwatch.
- Everything runs in one clk domain; no derived clocks. Button input is synchronised and edge-detected internally.
- The stopwatch keeps running in every mode. Display output is registered.

Parameters:
- CLK_HZ, 50000000, input clock frequency. Must be a multiple of 100.
- NUM_ALARMS, 4, number of alarm slots (1..8).
- ALARM_LEN, 30, seconds an alarm LED stays lit unless acknowledged (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  0 normal, 1 set time, 2 set alarm, 3 stopwatch
- field_sel  in  2  0 sec, 1 min, 2 hour; 3 ignores increments
- alarm_sel  in  3  alarm slot to edit or show; values >= NUM_ALARMS ignore increments and show blank
- inc_btn  in  1  raw level; each rising edge is one increment
- alarm_en  in  NUM_ALARMS  per-slot alarm enable
- alarm_ack  in  1  level; clears all lit alarm LEDs
- sw_run  in  1  stopwatch runs while 1
- sw_clear  in  1  stopwatch clear
- hex0..hex5  out  7 each  active-low segments, bit0 = segment a; hex0 is the rightmost digit
- led  out  NUM_ALARMS  alarm indicators

Behaviour:
- Reset:
  - All time, alarm and stopwatch registers go to 0.
  - led = 0 and tick dividers = 0.
  - hex0..hex5 = 7'h40, i.e. "000000".
- Digit codes 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). Blank = 7F.
- Second tick:
  - Divider counts 0..CLK_HZ-1.
  - It asserts a one-cycle sec_tick on the cycle it wraps from CLK_HZ-1 to 0.
- Time advance: on sec_tick, when mode != 1:
  - sec 59 -> 0 carries into min.
  - min 59 -> 0 carries into hour.
  - hour 23 -> 0.
- Mode 1 (set time):
  - Time is frozen and the second divider is held at 0, so the first second after leaving mode 1 is a full second.
  - Each inc pulse increments the selected field by 1 and wraps that field only (59 -> 0 or 23 -> 0). There is no carry.
- inc pulse:
  - inc_btn passes through a 2-flop synchroniser, then a rising-edge detector.
  - The result is one pulse per press, 3 cycles after the edge.
- Mode 2 (set alarm):
  - inc pulse edits the selected field of alarm[alarm_sel], same wrap rule as mode 1.
  - Out-of-range alarm_sel: the increment is ignored.
- Alarm hit:
  - Evaluated only on the cycle time advances (sec_tick with mode != 1).
  - The new time value is compared against alarm[i] for every i with alarm_en[i] = 1.
  - On a match, led[i] is set and a per-slot seconds-remaining counter is loaded with ALARM_LEN.
- Alarm clear:
  - Each later sec_tick decrements the counter; led[i] clears when it reaches 0.
  - alarm_ack clears all LEDs and counters.
  - If a hit and alarm_ack occur in the same cycle, the hit wins.
  - Setting the time or an alarm never fires an alarm.
  - No alarm fires at reset.
- Stopwatch:
  - A separate divider produces cs_tick every CLK_HZ/100 cycles, counting only while sw_run = 1.
  - The divider holds its value while stopped, so resume continues mid-interval.
  - Fields: centiseconds 0..99, seconds 0..59, minutes 0..59.
  - 59:59.99 wraps to 00:00.00.
  - sw_clear zeroes the count and the divider, with priority over run and over a cs_tick in the same cycle.
  - Stopwatch state is unaffected by mode changes.
- Display (registered; the hex outputs update the cycle after any state change):
  - mode 0: hour, min, sec (hex5..hex0)
  - mode 1: time, frozen value
  - mode 2: alarm[alarm_sel]
  - mode 3: min, sec, centiseconds
- Reset mid-operation:
  - Immediate asynchronous return to the reset state.
  - A press in flight in the synchroniser is discarded.

Optional Feature:
- MULTI_ALARM_CLOCK_BLINK_EN defined:
  - In modes 1 and 2, the two digits of the field selected by field_sel are blanked (7F) during the second half of each second period.
  - A free-running divider drives the blink and keeps running in mode 1.
  - field_sel = 3 never blanks.
- Not defined: no blanking; display exactly as in Behaviour.

Test Plan (CLK_HZ = 1000):
- Reset, then run 3000 cycles in mode 0 -> display 000003. After sec_tick at 23:59:59 -> 00:00:00 with no led.
- Mode 1, field_sel = 1, five inc presses at 58 min -> min = 03, hour unchanged. Return to mode 0 -> no advance for 1000 cycles after the exit, then sec + 1.
- alarm[2] = 00:00:05, alarm_en = 4'b0100, run from 0 -> led = 4'b0100 at the tick where time becomes 5 s. led clears after 30 more ticks. Repeat with alarm_ack at 10 s -> led clears the next cycle.
- Alarm hit and alarm_ack asserted in the same cycle -> led set. alarm_en = 0 at the match time -> no led.
- Mode 3, sw_run = 1 for 1230 cycles -> "000123". Switch to mode 0 and back -> count has continued. sw_clear with sw_run = 1 -> 000000 on the next cycle.
- With BLINK_EN, mode 2, field_sel = 2 -> hex5/hex4 = 7F for cycles 500..999 of each period, other digits steady. inc_btn toggled 1 cycle after reset deasserts -> exactly one increment.

Source files
------------

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock
//   24-hour clock for a six-digit 7-segment display. It provides time keeping,
//   time set, NUM_ALARMS independent alarms and a 1/100 s stopwatch. Everything
//   runs in the single clk domain. The stopwatch runs regardless of mode.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   mode[1:0]       0 normal, 1 set time, 2 set alarm, 3 stopwatch
//   field_sel[1:0]  0 sec, 1 min, 2 hour, 3 = increments ignored
//   alarm_sel[2:0]  alarm slot to edit/show (>= NUM_ALARMS: ignored, blank)
//   inc_btn         raw button level, one increment per rising edge
//   alarm_en        per-slot alarm enable
//   alarm_ack       clears every lit alarm LED
//   sw_run          stopwatch runs while high
//   sw_clear        stopwatch clear (priority over run)
//   hex0..hex5      registered active-low segments, bit0 = a, hex0 rightmost
//   led             alarm indicators
//
// Build option
//   MULTI_ALARM_CLOCK_BLINK_EN: in modes 1 and 2 the selected field blanks
//   during the second half of every second period.

module multi_alarm_clock #(
    parameter int CLK_HZ     = 50000000,
    parameter int NUM_ALARMS = 4,
    parameter int ALARM_LEN  = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [1:0]            field_sel,
    input  logic [2:0]            alarm_sel,
    input  logic                  inc_btn,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  alarm_ack,
    input  logic                  sw_run,
    input  logic                  sw_clear,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [6:0]            hex4,
    output logic [6:0]            hex5,
    output logic [NUM_ALARMS-1:0] led
);

    localparam int CS_DIV = CLK_HZ / 100;
    localparam int DIV_W  = $clog2(CLK_HZ + 1);
    localparam int CS_W   = $clog2(CS_DIV + 1);
    localparam logic [DIV_W-1:0] SEC_LAST   = DIV_W'(CLK_HZ - 1);
    localparam logic [CS_W-1:0]  CS_LAST    = CS_W'(CS_DIV - 1);
    localparam logic [7:0]       ALARM_INIT = 8'(ALARM_LEN);

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    // Two BCD digits {tens, ones} of a value 0..99.
    function automatic logic [7:0] bcd2(input logic [6:0] v);
        logic [6:0] t;
        logic [6:0] o;
        t = v / 7'd10;
        o = v % 7'd10;
        return {t[3:0], o[3:0]};
    endfunction

    // Any code above 9 shows a blank digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic             btn_s1_q, btn_s2_q, btn_s3_q;
    logic             inc_pulse;
    logic [DIV_W-1:0] sec_div_q, sec_div_d;
    logic             sec_tick, advance;
    logic [5:0]       t_sec_q, t_sec_d, t_min_q, t_min_d;
    logic [4:0]       t_hour_q, t_hour_d;
    logic [5:0]       a_sec_q  [NUM_ALARMS];
    logic [5:0]       a_sec_d  [NUM_ALARMS];
    logic [5:0]       a_min_q  [NUM_ALARMS];
    logic [5:0]       a_min_d  [NUM_ALARMS];
    logic [4:0]       a_hour_q [NUM_ALARMS];
    logic [4:0]       a_hour_d [NUM_ALARMS];
    logic [7:0]       cnt_q    [NUM_ALARMS];
    logic [7:0]       cnt_d    [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] led_q, led_d, hit;
    logic [CS_W-1:0]  sw_div_q, sw_div_d;
    logic             sw_tick;
    logic [6:0]       sw_cs_q, sw_cs_d;
    logic [5:0]       sw_sec_q, sw_sec_d, sw_min_q, sw_min_d;
    logic [23:0]      dig;
    logic [6:0]       hex_q [6];
    logic [6:0]       hex_d [6];
`ifdef MULTI_ALARM_CLOCK_BLINK_EN
    localparam logic [DIV_W-1:0] BLINK_HALF = DIV_W'(CLK_HZ / 2);
    logic [DIV_W-1:0] blink_q, blink_d;
    always_comb blink_d = (blink_q == SEC_LAST) ? '0 : blink_q + 1'b1;
`endif

    // Button: 2-flop synchroniser then rising-edge detect on the synced level.
    assign inc_pulse = btn_s2_q & ~btn_s3_q;

    // Time keeping and time set. The divider is held at 0 in set-time mode so
    // the first second after leaving it is a full one.
    always_comb begin
        sec_tick  = (sec_div_q == SEC_LAST);
        advance   = sec_tick && (mode != 2'd1);
        sec_div_d = (mode == 2'd1 || sec_tick) ? '0 : sec_div_q + 1'b1;
        t_sec_d   = t_sec_q;
        t_min_d   = t_min_q;
        t_hour_d  = t_hour_q;
        if (advance) begin
            t_sec_d = inc60(t_sec_q);
            if (t_sec_q == 6'd59) begin
                t_min_d = inc60(t_min_q);
                if (t_min_q == 6'd59) t_hour_d = inc24(t_hour_q);
            end
        end else if (mode == 2'd1 && inc_pulse) begin
            case (field_sel)
                2'd0:    t_sec_d  = inc60(t_sec_q);
                2'd1:    t_min_d  = inc60(t_min_q);
                2'd2:    t_hour_d = inc24(t_hour_q);
                default: ;
            endcase
        end
    end

    // Alarm edit, hit detection and LED hold-off. A hit compares against the
    // time value being loaded this cycle; a hit outranks a simultaneous ack.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            a_sec_d[i]  = a_sec_q[i];
            a_min_d[i]  = a_min_q[i];
            a_hour_d[i] = a_hour_q[i];
            cnt_d[i]    = cnt_q[i];
            led_d[i]    = led_q[i];
            if (mode == 2'd2 && inc_pulse && alarm_sel == 3'(i)) begin
                case (field_sel)
                    2'd0:    a_sec_d[i]  = inc60(a_sec_q[i]);
                    2'd1:    a_min_d[i]  = inc60(a_min_q[i]);
                    2'd2:    a_hour_d[i] = inc24(a_hour_q[i]);
                    default: ;
                endcase
            end
            hit[i] = advance && alarm_en[i] && (t_sec_d == a_sec_q[i]) &&
                     (t_min_d == a_min_q[i]) && (t_hour_d == a_hour_q[i]);
            if (hit[i]) begin
                led_d[i] = 1'b1;
                cnt_d[i] = ALARM_INIT;
            end else if (alarm_ack) begin
                led_d[i] = 1'b0;
                cnt_d[i] = 8'd0;
            end else if (sec_tick && cnt_q[i] != 8'd0) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
                if (cnt_q[i] == 8'd1) led_d[i] = 1'b0;
            end
        end
    end

    // Stopwatch. The divider only counts while running, so a resume continues
    // mid-interval; clear beats both run and a same-cycle tick.
    always_comb begin
        sw_tick  = sw_run && (sw_div_q == CS_LAST);
        sw_div_d = sw_div_q;
        sw_cs_d  = sw_cs_q;
        sw_sec_d = sw_sec_q;
        sw_min_d = sw_min_q;
        if (sw_clear) begin
            sw_div_d = '0;
            sw_cs_d  = '0;
            sw_sec_d = '0;
            sw_min_d = '0;
        end else if (sw_run) begin
            sw_div_d = sw_tick ? '0 : sw_div_q + 1'b1;
            if (sw_tick) begin
                sw_cs_d = (sw_cs_q == 7'd99) ? 7'd0 : sw_cs_q + 7'd1;
                if (sw_cs_q == 7'd99) begin
                    sw_sec_d = inc60(sw_sec_q);
                    if (sw_sec_q == 6'd59) sw_min_d = inc60(sw_min_q);
                end
            end
        end
    end

    // Display digit selection; dig[23:20] is hex5.
    always_comb begin
        case (mode)
            2'd3: dig = {bcd2(7'(sw_min_q)), bcd2(7'(sw_sec_q)), bcd2(sw_cs_q)};
            2'd2: begin
                dig = 24'hFFFFFF;
                for (int i = 0; i < NUM_ALARMS; i++) begin
                    if (alarm_sel == 3'(i))
                        dig = {bcd2(7'(a_hour_q[i])), bcd2(7'(a_min_q[i])), bcd2(7'(a_sec_q[i]))};
                end
            end
            default: dig = {bcd2(7'(t_hour_q)), bcd2(7'(t_min_q)), bcd2(7'(t_sec_q))};
        endcase
`ifdef MULTI_ALARM_CLOCK_BLINK_EN
        if ((mode == 2'd1 || mode == 2'd2) && blink_q >= BLINK_HALF) begin
            case (field_sel)
                2'd0:    dig[7:0]   = 8'hFF;
                2'd1:    dig[15:8]  = 8'hFF;
                2'd2:    dig[23:16] = 8'hFF;
                default: ;
            endcase
        end
`endif
        for (int k = 0; k < 6; k++) hex_d[k] = seg7(dig[4*k +: 4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            btn_s3_q  <= 1'b0;
            sec_div_q <= '0;
            t_sec_q   <= '0;
            t_min_q   <= '0;
            t_hour_q  <= '0;
            led_q     <= '0;
            sw_div_q  <= '0;
            sw_cs_q   <= '0;
            sw_sec_q  <= '0;
            sw_min_q  <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                a_sec_q[i]  <= '0;
                a_min_q[i]  <= '0;
                a_hour_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            for (int k = 0; k < 6; k++) hex_q[k] <= 7'h40;
`ifdef MULTI_ALARM_CLOCK_BLINK_EN
            blink_q <= '0;
`endif
        end else begin
            btn_s1_q  <= inc_btn;
            btn_s2_q  <= btn_s1_q;
            btn_s3_q  <= btn_s2_q;
            sec_div_q <= sec_div_d;
            t_sec_q   <= t_sec_d;
            t_min_q   <= t_min_d;
            t_hour_q  <= t_hour_d;
            led_q     <= led_d;
            sw_div_q  <= sw_div_d;
            sw_cs_q   <= sw_cs_d;
            sw_sec_q  <= sw_sec_d;
            sw_min_q  <= sw_min_d;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                a_sec_q[i]  <= a_sec_d[i];
                a_min_q[i]  <= a_min_d[i];
                a_hour_q[i] <= a_hour_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            for (int k = 0; k < 6; k++) hex_q[k] <= hex_d[k];
`ifdef MULTI_ALARM_CLOCK_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign led  = led_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

    localparam int CLK_HZ = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [1:0] field_sel = 2'd0;
    logic [2:0] alarm_sel = 3'd0;
    logic       inc_btn = 1'b0;
    logic [3:0] alarm_en = 4'd0;
    logic       alarm_ack = 1'b0;
    logic       sw_run = 1'b0;
    logic       sw_clear = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [3:0] led;

    always #5 clk = ~clk;

    multi_alarm_clock #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(4), .ALARM_LEN(30)) dut (
        .clk(clk), .rst(rst), .mode(mode), .field_sel(field_sel),
        .alarm_sel(alarm_sel), .inc_btn(inc_btn), .alarm_en(alarm_en),
        .alarm_ack(alarm_ack), .sw_run(sw_run), .sw_clear(sw_clear),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
        .hex5(hex5), .led(led)
    );

    typedef struct {
        string       name;
        logic [41:0] hex;
        logic [3:0]  led;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [41:0] dut_hex;
    assign dut_hex = {hex5, hex4, hex3, hex2, hex1, hex0};

    // Expected display for three two-digit groups, left to right.
    function automatic logic [41:0] disp(input int a, input int b, input int c);
        return {seg_tab[a / 10], seg_tab[a % 10], seg_tab[b / 10],
                seg_tab[b % 10], seg_tab[c / 10], seg_tab[c % 10]};
    endfunction

    // All stimulus changes and all sampling happen on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        inc_btn = 1'b1;
        step(4);
        inc_btn = 1'b0;
        step(4);
    endtask

    task automatic presses(input int n);
        repeat (n) press();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'd0;
        alarm_en = 4'hF;
        rst = 1'b1;
        exp_q.push_back('{"reset_hold", disp(0, 0, 0), 4'b0000});
        step(2);
        e = exp_q.pop_front(); n_cmp++;
        if (dut_hex !== e.hex || led !== e.led) begin
            n_bad++;
            $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
        end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        rst = 1'b0;
        exp_q.push_back('{"no_alarm_at_reset", disp(0, 0, 0), 4'b0000});
        exp_q.push_back('{"run_3000_cycles", disp(0, 0, 3), 4'b0000});
        step(10);
        e = exp_q.pop_front(); n_cmp++;
        if (dut_hex !== e.hex || led !== e.led) begin
            n_bad++;
            $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
        end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        step(2991);
        e = exp_q.pop_front(); n_cmp++;
        if (dut_hex !== e.hex || led !== e.led) begin
            n_bad++;
            $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
        end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
    endtask

    task automatic test_rollover();
        alarm_en = 4'd0;
        mode = 2'd1;
        apply_reset();
        field_sel = 2'd2; presses(23);
        field_sel = 2'd1; presses(59);
        field_sel = 2'd0; presses(59);
        exp_q.push_back('{"set_23_59_59", disp(23, 59, 59), 4'b0000});
        exp_q.push_back('{"no_tick_999", disp(23, 59, 59), 4'b0000});
        exp_q.push_back('{"midnight_wrap", disp(0, 0, 0), 4'b0000});
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin mode = 2'd0; step(999); end
            if (k == 2) step(2);
            e = exp_q.pop_front(); n_cmp++;
            if (dut_hex !== e.hex || led !== e.led) begin
                n_bad++;
                $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
            end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        end
    endtask

    task automatic test_set_time();
        mode = 2'd1;
        apply_reset();
        field_sel = 2'd2; presses(5);
        field_sel = 2'd1; presses(58);
        exp_q.push_back('{"min_58", disp(5, 58, 0), 4'b0000});
        exp_q.push_back('{"min_wrap_no_carry", disp(5, 3, 0), 4'b0000});
        exp_q.push_back('{"field3_ignored", disp(5, 3, 0), 4'b0000});
        exp_q.push_back('{"exit_full_second", disp(5, 3, 0), 4'b0000});
        exp_q.push_back('{"exit_first_tick", disp(5, 3, 1), 4'b0000});
        for (int k = 0; k < 5; k++) begin
            case (k)
                1: presses(5);
                2: begin field_sel = 2'd3; presses(2); end
                3: begin mode = 2'd0; step(999); end
                4: step(2);
                default: ;
            endcase
            e = exp_q.pop_front(); n_cmp++;
            if (dut_hex !== e.hex || led !== e.led) begin
                n_bad++;
                $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
            end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        end
    endtask

    task automatic test_alarm_expire();
        alarm_en = 4'd0;
        mode = 2'd2;
        alarm_sel = 3'd2;
        field_sel = 2'd0;
        apply_reset();
        presses(5);
        exp_q.push_back('{"alarm2_shown", disp(0, 0, 5), 4'b0000});
        exp_q.push_back('{"alarm_sel_oob_blank", {6{7'h7F}}, 4'b0000});
        exp_q.push_back('{"alarm2_unchanged", disp(0, 0, 5), 4'b0000});
        exp_q.push_back('{"before_hit", disp(0, 0, 4), 4'b0000});
        exp_q.push_back('{"hit_at_5s", disp(0, 0, 4), 4'b0100});
        exp_q.push_back('{"hit_display", disp(0, 0, 5), 4'b0100});
        exp_q.push_back('{"led_held_29_ticks", disp(0, 0, 34), 4'b0100});
        exp_q.push_back('{"led_expired_30_ticks", disp(0, 0, 34), 4'b0000});
        for (int k = 0; k < 8; k++) begin
            case (k)
                1: begin alarm_sel = 3'd5; presses(2); end
                2: begin alarm_sel = 3'd2; step(1); end
                3: begin
                    alarm_en = 4'b0100;
                    mode = 2'd1; step(2);
                    mode = 2'd0; step(4999);
                end
                4, 5: step(1);
                6: step(29998);
                7: step(1);
                default: ;
            endcase
            e = exp_q.pop_front(); n_cmp++;
            if (dut_hex !== e.hex || led !== e.led) begin
                n_bad++;
                $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
            end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        end
    endtask

    task automatic test_alarm_ack();
        alarm_en = 4'd0;
        mode = 2'd2;
        alarm_sel = 3'd2;
        field_sel = 2'd0;
        apply_reset();
        presses(5);
        alarm_en = 4'b0100;
        mode = 2'd1; step(2);
        mode = 2'd0;
        exp_q.push_back('{"ack_test_hit", disp(0, 0, 4), 4'b0100});
        exp_q.push_back('{"ack_clears_next_cycle", disp(0, 0, 10), 4'b0000});
        step(5000);
        e = exp_q.pop_front(); n_cmp++;
        if (dut_hex !== e.hex || led !== e.led) begin
            n_bad++;
            $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
        end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        step(5000);
        alarm_ack = 1'b1;
        step(1);
        e = exp_q.pop_front(); n_cmp++;
        if (dut_hex !== e.hex || led !== e.led) begin
            n_bad++;
            $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
        end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        alarm_ack = 1'b0;
    endtask

    // Slots 0 and 1 both match at 00:00:05; only slot 0 is enabled, and ack
    // is already high on the matching cycle.
    task automatic test_hit_and_ack();
        alarm_en = 4'd0;
        mode = 2'd2;
        field_sel = 2'd0;
        apply_reset();
        alarm_sel = 3'd0; presses(5);
        alarm_sel = 3'd1; presses(5);
        alarm_en = 4'b0001;
        mode = 2'd1; step(2);
        mode = 2'd0;
        exp_q.push_back('{"hit_beats_ack", disp(0, 0, 4), 4'b0001});
        exp_q.push_back('{"ack_after_hit", disp(0, 0, 5), 4'b0000});
        step(4999);
        alarm_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(1);
            e = exp_q.pop_front(); n_cmp++;
            if (dut_hex !== e.hex || led !== e.led) begin
                n_bad++;
                $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
            end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        end
        alarm_ack = 1'b0;
    endtask

    task automatic test_stopwatch();
        alarm_en = 4'd0;
        mode = 2'd3;
        apply_reset();
        exp_q.push_back('{"sw_1230_cycles", disp(0, 1, 23), 4'b0000});
        exp_q.push_back('{"sw_runs_in_mode0", disp(0, 1, 73), 4'b0000});
        exp_q.push_back('{"sw_resume_mid_interval", disp(0, 1, 74), 4'b0000});
        exp_q.push_back('{"sw_clear_beats_run", disp(0, 0, 0), 4'b0000});
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin sw_run = 1'b1; step(1230); sw_run = 1'b0; step(1); end
                1: begin
                    sw_run = 1'b1; mode = 2'd0; step(500);
                    mode = 2'd3; sw_run = 1'b0; step(1);
                end
                2: begin
                    sw_run = 1'b1; step(5); sw_run = 1'b0; step(20);
                    sw_run = 1'b1; step(5); sw_run = 1'b0; step(1);
                end
                default: begin sw_run = 1'b1; sw_clear = 1'b1; step(2); end
            endcase
            e = exp_q.pop_front(); n_cmp++;
            if (dut_hex !== e.hex || led !== e.led) begin
                n_bad++;
                $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
            end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        end
        sw_clear = 1'b0;
        sw_run = 1'b0;
    endtask

    // Press right after reset release, then watch the hour field of alarm 0
    // across the blink phase of a free-running second divider.
    task automatic test_blink();
        logic [41:0] mid;
`ifdef MULTI_ALARM_CLOCK_BLINK_EN
        mid = {7'h7F, 7'h7F, seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[0]};
`else
        mid = disp(1, 0, 0);
`endif
        alarm_en = 4'd0;
        mode = 2'd2;
        alarm_sel = 3'd0;
        field_sel = 2'd2;
        apply_reset();
        step(1);
        press();
        exp_q.push_back('{"one_inc_after_reset", disp(1, 0, 0), 4'b0000});
        exp_q.push_back('{"blink_first_half", disp(1, 0, 0), 4'b0000});
        exp_q.push_back('{"blink_second_half", mid, 4'b0000});
        exp_q.push_back('{"blink_next_period", disp(1, 0, 0), 4'b0000});
        for (int k = 0; k < 4; k++) begin
            case (k)
                1: step(291);
                2, 3: step(400);
                default: ;
            endcase
            e = exp_q.pop_front(); n_cmp++;
            if (dut_hex !== e.hex || led !== e.led) begin
                n_bad++;
                $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
            end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        end
    endtask

    // Reset must take effect without waiting for a clock edge.
    task automatic test_async_reset();
        exp_q.push_back('{"async_reset", disp(0, 0, 0), 4'b0000});
        rst = 1'b1;
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (dut_hex !== e.hex || led !== e.led) begin
            n_bad++;
            $display("FAIL %s: hex=%h led=%b, expected hex=%h led=%b", e.name, dut_hex, led, e.hex, e.led);
        end else $display("ok   %s: hex=%h led=%b", e.name, dut_hex, led);
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_set_time();
        test_alarm_expire();
        test_alarm_ack();
        test_hit_and_ack();
        test_stopwatch();
        test_blink();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
